// File: rtl/io_periph_pkg.sv
// Shared constants for io_periph_ctrl: register word offsets, TCTRL bit positions,
// the active-low hex glyph table and a byte-lane merge helper.
package io_periph_pkg;

  localparam logic [5:0] REG_LED      = 6'd0;
  localparam logic [5:0] REG_RGB      = 6'd1;
  localparam logic [5:0] REG_NUM_DATA = 6'd2;
  localparam logic [5:0] REG_NUM_EN   = 6'd3;
  localparam logic [5:0] REG_TCOUNT   = 6'd4;
  localparam logic [5:0] REG_TCMP     = 6'd5;
  localparam logic [5:0] REG_TCTRL    = 6'd6;

  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_AUTO = 1;
  localparam int TCTRL_IE   = 2;
  localparam int TCTRL_PEND = 8;

  // Segment order {a,b,c,d,e,f,g}, 0 lights the segment.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct packed {
    logic pend;
    logic ie;
    logic rld;
    logic en;
  } tctrl_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/io_periph_ctrl_seg7_scan.sv
// Seven-segment scanner: prescaler, digit index, per-digit blanking and glyph lookup.
// Outputs registered, one cycle behind the digit index; free-running, no backpressure.
module seg7_scan
  import io_periph_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         num_data,
  input  logic [N_DIGITS-1:0] num_en,
  output logic [N_DIGITS-1:0] num_csn,
  output logic [6:0]          num_a_g
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [N_DIGITS-1:0] csn_q, csn_d;
  logic [6:0]          seg_q, seg_d;
  logic [3:0]          nib;

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PRE_LAST) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  always_comb begin
    nib   = 4'(num_data >> {idx_q, 2'b00});
    csn_d = '1;
    seg_d = 7'h7F;
    if (num_en[idx_q]) begin
      csn_d[idx_q] = 1'b0;
      seg_d        = SEG_LUT[nib];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      csn_q   <= '1;
      seg_q   <= 7'h7F;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      csn_q   <= csn_d;
      seg_q   <= seg_d;
    end
  end

  assign num_csn = csn_q;
  assign num_a_g = seg_q;

endmodule

// File: rtl/io_periph_ctrl.sv
// Memory-mapped LED/RGB/7-seg/compare-timer peripheral on the dev_if IO port.
// Writes land at the sampling edge, reads return one cycle later; always ready, no backpressure.
module io_periph_ctrl
  import io_periph_pkg::*;
#(
  parameter int N_LED    = 16,
  parameter int N_DIGITS = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic [3:0]          we,
  input  logic [31:0]         addr,
  input  logic [31:0]         din,
  output logic [31:0]         dout,
  output logic [N_LED-1:0]    led,
  output logic [2:0]          rgb_reg0,
  output logic [2:0]          rgb_reg1,
  output logic [N_DIGITS-1:0] num_csn,
  output logic [6:0]          num_a_g,
  output logic                timer_irq
);

  logic [5:0]          sel;
  logic                wr, rd, match;
  logic [31:0]         rdata;
  logic                unused_ok;

  logic [N_LED-1:0]    led_q, led_d;
  logic [2:0]          rgb0_q, rgb0_d, rgb1_q, rgb1_d;
  logic [31:0]         num_data_q, num_data_d;
  logic [N_DIGITS-1:0] num_en_q, num_en_d;
  logic [31:0]         tcount_q, tcount_d, tcmp_q, tcmp_d;
  tctrl_t              tc_q, tc_d;
  logic                irq_q, irq_d;
  logic [31:0]         dout_q, dout_d;

  assign sel       = addr[7:2];
  assign wr        = ce & (|we);
  assign rd        = ce & ~(|we);
  assign match     = tc_q.en & (tcount_q == tcmp_q);
  assign unused_ok = &{1'b0, addr[31:8], addr[1:0]};

  always_comb begin
    led_d      = led_q;
    rgb0_d     = rgb0_q;
    rgb1_d     = rgb1_q;
    num_data_d = num_data_q;
    num_en_d   = num_en_q;
    tcmp_d     = tcmp_q;
    if (wr) begin
      unique case (sel)
        REG_LED:      led_d      = N_LED'(byte_merge(32'(led_q), din, we));
        REG_RGB: begin
          if (we[0]) begin
            rgb0_d = din[2:0];
            rgb1_d = din[6:4];
          end
        end
        REG_NUM_DATA: num_data_d = byte_merge(num_data_q, din, we);
        REG_NUM_EN:   num_en_d   = N_DIGITS'(byte_merge(32'(num_en_q), din, we));
        REG_TCMP:     tcmp_d     = byte_merge(tcmp_q, din, we);
        default: ;
      endcase
    end
  end

  // Priority, lowest first: count/reload, then software writes; PEND set beats W1C.
  always_comb begin
    tcount_d = tcount_q;
    tc_d     = tc_q;
    if (tc_q.en) begin
      if (match) tcount_d = tc_q.rld ? 32'd0 : tcount_q;
      else       tcount_d = tcount_q + 32'd1;
    end
    if (match && !tc_q.rld) tc_d.en = 1'b0;
    if (wr && sel == REG_TCOUNT) tcount_d = byte_merge(tcount_q, din, we);
    if (wr && sel == REG_TCTRL) begin
      if (we[0]) begin
        tc_d.en  = din[TCTRL_EN];
        tc_d.rld = din[TCTRL_AUTO];
        tc_d.ie  = din[TCTRL_IE];
      end
      if (we[1] && din[TCTRL_PEND]) tc_d.pend = 1'b0;
    end
    if (match) tc_d.pend = 1'b1;
    irq_d = tc_q.pend & tc_q.ie;
  end

  always_comb begin
    rdata = 32'd0;
    unique case (sel)
      REG_LED:      rdata = 32'(led_q);
      REG_RGB:      rdata = {25'd0, rgb1_q, 1'b0, rgb0_q};
      REG_NUM_DATA: rdata = num_data_q;
      REG_NUM_EN:   rdata = 32'(num_en_q);
      REG_TCOUNT:   rdata = tcount_q;
      REG_TCMP:     rdata = tcmp_q;
      REG_TCTRL:    rdata = {23'd0, tc_q.pend, 5'd0, tc_q.ie, tc_q.rld, tc_q.en};
      default:      rdata = 32'd0;
    endcase
    dout_d = rd ? rdata : dout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q      <= '0;
      rgb0_q     <= '0;
      rgb1_q     <= '0;
      num_data_q <= '0;
      num_en_q   <= '1;
      tcount_q   <= '0;
      tcmp_q     <= 32'hFFFF_FFFF;
      tc_q       <= '0;
      irq_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      led_q      <= led_d;
      rgb0_q     <= rgb0_d;
      rgb1_q     <= rgb1_d;
      num_data_q <= num_data_d;
      num_en_q   <= num_en_d;
      tcount_q   <= tcount_d;
      tcmp_q     <= tcmp_d;
      tc_q       <= tc_d;
      irq_q      <= irq_d;
      dout_q     <= dout_d;
    end
  end

  seg7_scan #(
    .N_DIGITS (N_DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .num_data (num_data_q),
    .num_en   (num_en_q),
    .num_csn  (num_csn),
    .num_a_g  (num_a_g)
  );

  assign dout      = dout_q;
  assign led       = led_q;
  assign rgb_reg0  = rgb0_q;
  assign rgb_reg1  = rgb1_q;
  assign timer_irq = irq_q;

endmodule

// File: tb/tb_io_periph_ctrl.sv
// Directed bench for io_periph_ctrl with N_LED=32, N_DIGITS=4, SCAN_DIV=4.
module tb_io_periph_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic [3:0]  we = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic [31:0] led;
  logic [2:0]  rgb_reg0, rgb_reg1;
  logic [3:0]  num_csn;
  logic [6:0]  num_a_g;
  logic        timer_irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  localparam logic [31:0] A_LED = 32'h00, A_RGB = 32'h04, A_NDAT = 32'h08, A_NEN = 32'h0C;
  localparam logic [31:0] A_TCNT = 32'h10, A_TCMP = 32'h14, A_TCTL = 32'h18;

  io_periph_ctrl #(.N_LED(32), .N_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .we(we), .addr(addr), .din(din), .dout(dout),
    .led(led), .rgb_reg0(rgb_reg0), .rgb_reg1(rgb_reg1), .num_csn(num_csn),
    .num_a_g(num_a_g), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  // Edges since the last reset release; drives the expected scan position.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    ce = 1'b1; we = be; addr = a; din = d;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 4'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    ce = 1'b1; we = 4'd0; addr = a;
    @(posedge clk);
    #1;
    ce = 1'b0;
    @(posedge clk);
    #1;
    d = dout;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    rst_n = 1'b0;
    cycles(2);
    checks++;
    if ({led, rgb_reg0, rgb_reg1, dout} !== 70'd0) begin
      failures++; $display("FAIL reset_regs got led=%h rgb0=%h rgb1=%h dout=%h exp all 0", led, rgb_reg0, rgb_reg1, dout);
    end
    checks++;
    if (num_csn !== 4'hF || num_a_g !== 7'h7F || timer_irq !== 1'b0) begin
      failures++; $display("FAIL reset_pins got csn=%b seg=%h irq=%b exp 1111/7f/0", num_csn, num_a_g, timer_irq);
    end
    rst_n = 1'b1;
    cycles(1);
    checks++;
    if (num_csn !== 4'b1110 || num_a_g !== 7'h01) begin
      failures++; $display("FAIL first_digit got csn=%b seg=%h exp 1110/01", num_csn, num_a_g);
    end
    bus_read(A_NEN, r);
    checks++;
    if (r !== 32'h0000000F) begin failures++; $display("FAIL num_en_reset got=%h exp=0000000f", r); end
    bus_read(A_TCMP, r);
    checks++;
    if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL tcmp_reset got=%h exp=ffffffff", r); end
  endtask

  task automatic test_byte_write;
    logic [31:0] r;
    bus_write(A_LED, 32'hAABBCCDD, 4'b0101);
    checks++;
    if (led !== 32'h00BB00DD) begin failures++; $display("FAIL byte_write_led got=%h exp=00bb00dd", led); end
    bus_read(A_LED, r);
    checks++;
    if (r !== 32'h00BB00DD) begin failures++; $display("FAIL byte_write_read got=%h exp=00bb00dd", r); end
    bus_write(A_LED, 32'h11223344, 4'b1000);
    checks++;
    if (led !== 32'h11BB00DD) begin failures++; $display("FAIL byte_write_top got=%h exp=11bb00dd", led); end
  endtask

  task automatic test_regs;
    logic [31:0] r;
    bus_write(A_RGB, 32'hFFFFFFFF, 4'b1111);
    checks++;
    if (rgb_reg0 !== 3'd7 || rgb_reg1 !== 3'd7) begin
      failures++; $display("FAIL rgb_pins got %h/%h exp 7/7", rgb_reg0, rgb_reg1);
    end
    bus_read(A_RGB, r);
    checks++;
    if (r !== 32'h00000077) begin failures++; $display("FAIL rgb_read got=%h exp=00000077", r); end
    bus_write(A_RGB, 32'h00000025, 4'b0001);
    checks++;
    if (rgb_reg0 !== 3'd5 || rgb_reg1 !== 3'd2) begin
      failures++; $display("FAIL rgb_pins2 got %h/%h exp 5/2", rgb_reg0, rgb_reg1);
    end
    bus_write(32'h20, 32'hDEADBEEF, 4'b1111);
    checks++;
    if (led !== 32'h11BB00DD) begin failures++; $display("FAIL unmapped_write led got=%h exp=11bb00dd", led); end
    bus_read(32'h1C, r);
    checks++;
    if (r !== 32'd0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", r); end
    bus_read(32'h03, r);
    checks++;
    if (r !== 32'h11BB00DD) begin failures++; $display("FAIL addr_low_ignored got=%h exp=11bb00dd", r); end
  endtask

  task automatic test_timer_auto;
    logic [31:0] r;
    bus_write(A_TCNT, 32'd0, 4'b1111);
    bus_write(A_TCMP, 32'd5, 4'b1111);
    bus_write(A_TCTL, 32'h7, 4'b0001);
    cycles(6);
    checks++;
    if (timer_irq !== 1'b0) begin failures++; $display("FAIL auto_irq_early got=%b exp=0", timer_irq); end
    cycles(1);
    checks++;
    if (timer_irq !== 1'b1) begin failures++; $display("FAIL auto_irq_first got=%b exp=1", timer_irq); end
    bus_write(A_TCTL, 32'h100, 4'b0010);
    cycles(1);
    checks++;
    if (timer_irq !== 1'b0) begin failures++; $display("FAIL auto_w1c_drop got=%b exp=0", timer_irq); end
    cycles(3);
    checks++;
    if (timer_irq !== 1'b0) begin failures++; $display("FAIL auto_irq_gap got=%b exp=0", timer_irq); end
    cycles(1);
    checks++;
    if (timer_irq !== 1'b1) begin failures++; $display("FAIL auto_irq_second got=%b exp=1", timer_irq); end
    bus_read(A_TCNT, r);
    checks++;
    if (r !== 32'd1) begin failures++; $display("FAIL auto_restart_count got=%h exp=1", r); end
    bus_write(A_TCTL, 32'h100, 4'b0011);
  endtask

  task automatic test_one_shot;
    logic [31:0] r;
    bus_write(A_TCNT, 32'd0, 4'b1111);
    bus_write(A_TCMP, 32'd3, 4'b1111);
    bus_write(A_TCTL, 32'h5, 4'b0001);
    cycles(4);
    checks++;
    if (timer_irq !== 1'b0) begin failures++; $display("FAIL oneshot_irq_early got=%b exp=0", timer_irq); end
    cycles(1);
    checks++;
    if (timer_irq !== 1'b1) begin failures++; $display("FAIL oneshot_irq got=%b exp=1", timer_irq); end
    bus_read(A_TCTL, r);
    checks++;
    if (r !== 32'h00000104) begin failures++; $display("FAIL oneshot_tctrl got=%h exp=00000104", r); end
    bus_read(A_TCNT, r);
    checks++;
    if (r !== 32'd3) begin failures++; $display("FAIL oneshot_hold got=%h exp=3", r); end
  endtask

  task automatic test_collision;
    logic [31:0] r;
    bus_write(A_TCTL, 32'h100, 4'b0011);
    bus_write(A_TCNT, 32'd0, 4'b1111);
    bus_write(A_TCTL, 32'h7, 4'b0001);
    cycles(3);
    bus_write(A_TCTL, 32'h100, 4'b0010);
    bus_read(A_TCTL, r);
    checks++;
    if (r !== 32'h00000107) begin failures++; $display("FAIL w1c_vs_set got=%h exp=00000107", r); end
    bus_write(A_TCTL, 32'h100, 4'b0011);
    bus_write(A_TCNT, 32'd0, 4'b1111);
    bus_write(A_TCTL, 32'h3, 4'b0001);
    cycles(3);
    bus_write(A_TCNT, 32'h100, 4'b1111);
    bus_read(A_TCNT, r);
    checks++;
    if (r !== 32'h00000100) begin failures++; $display("FAIL tcount_write_vs_reload got=%h exp=00000100", r); end
  endtask

  task automatic test_reset_midrun;
    logic [31:0] r;
    bus_write(A_TCTL, 32'h7, 4'b0001);
    cycles(2);
    checks++;
    if (timer_irq !== 1'b1) begin failures++; $display("FAIL midrun_pre_irq got=%b exp=1", timer_irq); end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({led, rgb_reg0, rgb_reg1, dout} !== 70'd0) begin
      failures++; $display("FAIL midrun_reset_regs got led=%h rgb0=%h rgb1=%h dout=%h exp all 0", led, rgb_reg0, rgb_reg1, dout);
    end
    checks++;
    if (num_csn !== 4'hF || num_a_g !== 7'h7F || timer_irq !== 1'b0) begin
      failures++; $display("FAIL midrun_reset_pins got csn=%b seg=%h irq=%b exp 1111/7f/0", num_csn, num_a_g, timer_irq);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycles(1);
    checks++;
    if (num_csn !== 4'b1110 || num_a_g !== 7'h01) begin
      failures++; $display("FAIL midrun_first_digit got csn=%b seg=%h exp 1110/01", num_csn, num_a_g);
    end
    bus_read(A_TCMP, r);
    checks++;
    if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL midrun_tcmp got=%h exp=ffffffff", r); end
    bus_read(A_TCTL, r);
    checks++;
    if (r !== 32'd0) begin failures++; $display("FAIL midrun_tctrl got=%h exp=0", r); end
  endtask

  task automatic test_scan;
    int          dig;
    logic [3:0]  exp_csn;
    logic [6:0]  exp_seg;
    bus_write(A_NDAT, 32'h00008A10, 4'b1111);
    bus_write(A_NEN, 32'h0000000B, 4'b0001);
    cycles(1);
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      dig = ((cyc - 1) / 4) % 4;
      case (dig)
        0:       begin exp_csn = 4'b1110; exp_seg = 7'h01; end
        1:       begin exp_csn = 4'b1101; exp_seg = 7'h4F; end
        2:       begin exp_csn = 4'b1111; exp_seg = 7'h7F; end
        default: begin exp_csn = 4'b0111; exp_seg = 7'h00; end
      endcase
      checks++;
      if (num_csn !== exp_csn || num_a_g !== exp_seg) begin
        failures++;
        $display("FAIL scan cyc=%0d digit=%0d got csn=%b seg=%h exp csn=%b seg=%h",
                 cyc, dig, num_csn, num_a_g, exp_csn, exp_seg);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_byte_write();
    test_regs();
    test_timer_auto();
    test_one_shot();
    test_collision();
    test_reset_midrun();
    test_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
